multicycle_control: RTL and testbench

Multicycle MIPS control unit. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives every datapath enable and mux select from the current state. It replaces the single-cycle opcode decoder in the multicycle datapath and sits between the instruction register (opcode input) and the shared-memory/ALU/register-file datapath. It adds memory-latency wait counting, BNE/BEQ PC-enable resolution, J/JAL and an illegal-opcode pulse.

---
 rtl/mips_ctrl_pkg.sv | 69 ++++++
 rtl/mem_wait_counter.sv | 30 +++
 rtl/multicycle_control.sv | 162 ++++++++++++++++
 tb/tb_multicycle_control.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit, datapath and ALU control.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_LUI   = 3'b011;
  localparam logic [2:0] ALU_ADDI  = 3'b100;
  localparam logic [2:0] ALU_ORI   = 3'b101;
  localparam logic [2:0] ALU_ANDI  = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ADDI: return ALU_ADDI;
      OP_ANDI: return ALU_ANDI;
      OP_ORI:  return ALU_ORI;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Counts cycles spent in a memory state; 'last' marks the final cycle of the access.
module mem_wait_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en && !last) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign last = (count_q == LAST_CNT);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath, with memory wait counting
// and branch-resolved PC enable.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ALUOP_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic               Zero,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic               IllegalOp
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       last;
  logic       pc_write, branch_eq, branch_ne;
  logic [2:0] alu_op;

  // A state change always lands on a fresh count, so clearing on any transition
  // covers every entry into a memory state.
  mem_wait_counter #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
    .clk   (clk),
    .reset (reset),
    .clear (state_d != state_q),
    .en    (is_mem_state(state_q)),
    .last  (last)
  );

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (last) state_d = S_DECODE;
      S_DECODE: begin
        case (OP)
          OP_RTYPE:                         state_d = S_EXEC_R;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J, OP_JAL:                     state_d = S_JUMP;
          default:                          state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (last) state_d = S_MEM_WB;
      S_MEM_WR:   if (last) state_d = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:   state_d = S_ALU_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  // OP is only meaningful while the freshly loaded instruction sits in DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= OP;
    end
  end

  always_comb begin
    pc_write  = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = REGDST_RT;
    MemtoReg  = M2R_ALUOUT;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RT;
    alu_op    = ALU_ADD;
    PCSource  = PCSRC_ALU;
    IllegalOp = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        IRWrite  = last;
        pc_write = last;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        case (OP)
          OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
          OP_BEQ, OP_BNE, OP_J, OP_JAL: IllegalOp = 1'b0;
          default:                      IllegalOp = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        alu_op  = ALU_RTYPE;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_op  = imm_aluop(op_q);
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = (op_q == OP_RTYPE) ? REGDST_RD : REGDST_RT;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        alu_op    = ALU_SUB;
        PCSource  = PCSRC_ALUOUT;
        branch_eq = (op_q == OP_BEQ);
        branch_ne = (op_q == OP_BNE);
      end
      S_JUMP: begin
        pc_write = 1'b1;
        PCSource = PCSRC_JUMP;
        if (op_q == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RA;
          MemtoReg = M2R_PC;
        end
      end
      default: ;
    endcase
  end

  assign ALUOp = ALUOP_W'(alu_op);
  assign PCEn  = pc_write | (branch_eq & Zero) | (branch_ne & ~Zero);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control at latencies 1, 3 and 4, checked cycle by
// cycle against an instruction-timeline model built from the opcode rules.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsource;
    logic       illegal;
  } vec_t;

  localparam int NDUT = 3;
  localparam int LAT [NDUT] = '{1, 3, 4};

  logic             clk = 1'b0;
  logic [NDUT-1:0]  rst = '1;
  logic [5:0]       op_in = '0;
  logic             zero = 1'b0;
  vec_t             obs [NDUT];
  int               sel = 0;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic       pcen, iord, memread, memwrite, irwrite, regwrite, alusrca, illegal;
    logic [1:0] regdst, memtoreg, alusrcb, pcsource;
    logic [2:0] aluop;

    multicycle_control #(.MEM_LATENCY(LAT[g]), .ALUOP_W(3)) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .OP        (op_in),
      .Zero      (zero),
      .PCEn      (pcen),
      .IorD      (iord),
      .MemRead   (memread),
      .MemWrite  (memwrite),
      .IRWrite   (irwrite),
      .RegDst    (regdst),
      .MemtoReg  (memtoreg),
      .RegWrite  (regwrite),
      .ALUSrcA   (alusrca),
      .ALUSrcB   (alusrcb),
      .ALUOp     (aluop),
      .PCSource  (pcsource),
      .IllegalOp (illegal)
    );

    assign obs[g] = {pcen, iord, memread, memwrite, irwrite, regdst, memtoreg,
                     regwrite, alusrca, alusrcb, aluop, pcsource, illegal};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, act, exp);
  endtask

  // Expected per-cycle outputs of one instruction, from fetch through its last step.
  function automatic void build(input int lat, input logic [5:0] op, input logic z);
    vec_t v;
    exp_q.delete();
    for (int i = 0; i < lat; i++) begin
      v = '0; v.memread = 1'b1; v.alusrcb = 2'b01;
      if (i == lat - 1) begin v.irwrite = 1'b1; v.pcen = 1'b1; end
      exp_q.push_back(v);
    end
    v = '0; v.alusrcb = 2'b11;
    case (op)
      6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0F,
      6'h04, 6'h05, 6'h02, 6'h03: v.illegal = 1'b0;
      default:                    v.illegal = 1'b1;
    endcase
    exp_q.push_back(v);
    case (op)
      6'h00: begin
        v = '0; v.alusrca = 1'b1; v.aluop = 3'b111; exp_q.push_back(v);
        v = '0; v.regwrite = 1'b1; v.regdst = 2'b01; exp_q.push_back(v);
      end
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin
        v = '0; v.alusrca = 1'b1; v.alusrcb = 2'b10;
        v.aluop = (op == 6'h08) ? 3'b100 : (op == 6'h0C) ? 3'b110 :
                  (op == 6'h0D) ? 3'b101 : 3'b011;
        exp_q.push_back(v);
        v = '0; v.regwrite = 1'b1; exp_q.push_back(v);
      end
      6'h23, 6'h2B: begin
        v = '0; v.alusrca = 1'b1; v.alusrcb = 2'b10; exp_q.push_back(v);
        for (int i = 0; i < lat; i++) begin
          v = '0; v.iord = 1'b1;
          if (op == 6'h23) v.memread = 1'b1; else v.memwrite = 1'b1;
          exp_q.push_back(v);
        end
        if (op == 6'h23) begin
          v = '0; v.regwrite = 1'b1; v.memtoreg = 2'b01; exp_q.push_back(v);
        end
      end
      6'h04, 6'h05: begin
        v = '0; v.alusrca = 1'b1; v.aluop = 3'b001; v.pcsource = 2'b01;
        v.pcen = (op == 6'h04) ? z : ~z;
        exp_q.push_back(v);
      end
      6'h02, 6'h03: begin
        v = '0; v.pcen = 1'b1; v.pcsource = 2'b10;
        if (op == 6'h03) begin v.regwrite = 1'b1; v.regdst = 2'b10; v.memtoreg = 2'b10; end
        exp_q.push_back(v);
      end
      default: ;
    endcase
  endfunction

  // Entered #1 after a rising edge with the DUT in the first FETCH cycle.
  task automatic run_instr(input logic [5:0] op, input logic z, input int max_cyc);
    int lat = LAT[sel];
    build(lat, op, z);
    for (int i = 0; i < exp_q.size() && i < max_cyc; i++) begin
      op_in = (i == lat) ? op : 6'($urandom);
      zero  = (i == lat + 1) ? z : 1'($urandom);
      @(negedge clk);
      check($sformatf("L%0d op%02h z%0d cyc%0d", lat, op, z, i),
            {13'b0, obs[sel]}, {13'b0, exp_q[i]});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_dut(input int g);
    sel = g;
    rst[g] = 1'b1;
    @(posedge clk);
    #1;
    rst[g] = 1'b0;
  endtask

  task automatic random_instrs(input int n);
    logic [5:0] legal [11] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D,
                               6'h0F, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] op;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = legal[$urandom_range(0, 10)];
      run_instr(op, 1'($urandom), 1000);
    end
  endtask

  logic [5:0] dir_op [14] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0F,
                              6'h04, 6'h05, 6'h05, 6'h04, 6'h02, 6'h03, 6'h3F};
  logic       dir_z  [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    repeat (2) @(posedge clk);
    #1;

    // Latency 1: directed opcode sweep, then random mix.
    start_dut(0);
    for (int k = 0; k < 14; k++) run_instr(dir_op[k], dir_z[k], 1000);
    random_instrs(40);
    rst[0] = 1'b1;

    // Latency 3: LW first out of reset, then the sweep and random mix.
    start_dut(1);
    run_instr(6'h23, 1'b0, 1000);
    for (int k = 0; k < 14; k++) run_instr(dir_op[k], dir_z[k], 1000);
    random_instrs(40);
    rst[1] = 1'b1;

    // Latency 4: abort an SW in its second MEM_WR cycle, then resume cleanly.
    start_dut(2);
    run_instr(6'h2B, 1'b0, 4 + 2 + 2);
    start_dut(2);
    run_instr(6'h00, 1'b0, 1000);
    run_instr(6'h2B, 1'b0, 1000);
    random_instrs(20);
    rst[2] = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
